// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cd_state_t;
  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_ONES     = 4'd9;
  localparam bcd_t BCD_MAX_SEC_TENS = 4'd5;

  // {m_tens,m_ones,s_tens,s_ones}: every digit decimal, seconds tens at most 5
  function automatic logic bcd_load_valid(input logic [15:0] v);
    return (v[15:12] <= BCD_MAX_ONES) && (v[11:8] <= BCD_MAX_ONES) &&
           (v[7:4] <= BCD_MAX_SEC_TENS) && (v[3:0] <= BCD_MAX_ONES);
  endfunction

endpackage

// File: rtl/tick_countdown_if.sv
// Control/status bundle between the countdown timer and its controller.
interface tick_countdown_if;

  logic        tick_in;
  logic        load;
  logic [15:0] load_bcd;
  logic        start;
  logic        pause;
  logic        clear;
  logic [15:0] bcd_out;
  logic        running;
  logic        expired;
  logic        alarm;
  logic        load_err;

  modport master (
    output tick_in, load, load_bcd, start, pause, clear,
    input  bcd_out, running, expired, alarm, load_err
  );

  modport slave (
    input  tick_in, load, load_bcd, start, pause, clear,
    output bcd_out, running, expired, alarm, load_err
  );

endinterface

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit; wraps 0 -> MAX and flags a borrow to the next digit.
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter bcd_t MAX = BCD_MAX_ONES
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ld,
  input  bcd_t ld_val,
  output bcd_t digit,
  output logic borrow_out
);

  bcd_t r_digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit <= '0;
    end else if (ld) begin
      r_digit <= ld_val;
    end else if (en) begin
      r_digit <= (r_digit == '0) ? MAX : r_digit - 4'd1;
    end
  end

  assign digit      = r_digit;
  assign borrow_out = (r_digit == '0) & en;

endmodule

// File: rtl/tick_countdown.sv
// MM:SS countdown driven by a 1 Hz tick: FSM, tick edge detect, load validation, alarm timer.
module tick_countdown
  import timer_pkg::*;
#(
  parameter int EDGE_DETECT = 1,
  parameter int ALARM_TICKS = 0
) (
  input  logic             clk,
  input  logic             rst,
  tick_countdown_if.slave  bus
);

  localparam logic [31:0] ALARM_N = 32'(ALARM_TICKS);

  cd_state_t   r_state;
  cd_state_t   w_next;
  logic        r_tick_q;
  logic        r_running;
  logic        r_expired;
  logic        r_alarm;
  logic        r_load_err;
  logic [31:0] r_alarm_cnt;

  logic        w_tick_ev;
  logic        w_load_ok;
  logic        w_ld;
  logic [15:0] w_ld_val;
  logic        w_dec;
  logic        w_expire;
  logic [15:0] w_value;
  logic [3:0]  w_borrow;

  assign w_tick_ev = (EDGE_DETECT != 0) ? (bus.tick_in & ~r_tick_q) : bus.tick_in;
  assign w_load_ok = bus.load & bcd_load_valid(bus.load_bcd);

  assign w_ld     = bus.clear | w_load_ok;
  assign w_ld_val = bus.clear ? '0 : bus.load_bcd;

  // Any control input in the same cycle pre-empts the tick
  assign w_dec    = (r_state == RUN) & ~bus.clear & ~bus.load & ~bus.pause & w_tick_ev;
  assign w_expire = w_dec & (w_value == 16'h0001);

  bcd_digit_down #(.MAX(BCD_MAX_ONES)) u_s_ones (
    .clk(clk), .rst(rst), .en(w_dec), .ld(w_ld), .ld_val(w_ld_val[3:0]),
    .digit(w_value[3:0]), .borrow_out(w_borrow[0])
  );

  bcd_digit_down #(.MAX(BCD_MAX_SEC_TENS)) u_s_tens (
    .clk(clk), .rst(rst), .en(w_borrow[0]), .ld(w_ld), .ld_val(w_ld_val[7:4]),
    .digit(w_value[7:4]), .borrow_out(w_borrow[1])
  );

  bcd_digit_down #(.MAX(BCD_MAX_ONES)) u_m_ones (
    .clk(clk), .rst(rst), .en(w_borrow[1]), .ld(w_ld), .ld_val(w_ld_val[11:8]),
    .digit(w_value[11:8]), .borrow_out(w_borrow[2])
  );

  bcd_digit_down #(.MAX(BCD_MAX_ONES)) u_m_tens (
    .clk(clk), .rst(rst), .en(w_borrow[2]), .ld(w_ld), .ld_val(w_ld_val[15:12]),
    .digit(w_value[15:12]), .borrow_out(w_borrow[3])
  );

  always_comb begin
    w_next = r_state;
    if (bus.clear) begin
      w_next = IDLE;
    end else if (bus.load) begin
      if (w_load_ok) w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (bus.start && (w_value != '0)) w_next = RUN;
        RUN: begin
          if (bus.pause && !bus.start) w_next = PAUSE;
          else if (w_expire)           w_next = DONE;
        end
        PAUSE:   if (bus.start && !bus.pause) w_next = RUN;
        DONE:    w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tick_q    <= 1'b0;
      r_running   <= 1'b0;
      r_expired   <= 1'b0;
      r_alarm     <= 1'b0;
      r_load_err  <= 1'b0;
      r_alarm_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_tick_q   <= bus.tick_in;
      r_running  <= (w_next == RUN);
      r_expired  <= w_expire;
      r_load_err <= bus.load & ~bus.clear & ~w_load_ok;
      if (w_ld) begin
        r_alarm     <= 1'b0;
        r_alarm_cnt <= '0;
      end else if (w_expire) begin
        r_alarm     <= 1'b1;
        r_alarm_cnt <= '0;
      end else if ((r_state == DONE) && w_tick_ev && (ALARM_N != '0) && r_alarm) begin
        // Alarm drops on the Nth tick seen in DONE; counter freezes afterwards
        if (r_alarm_cnt + 32'd1 >= ALARM_N) r_alarm <= 1'b0;
        else                                r_alarm_cnt <= r_alarm_cnt + 32'd1;
      end
    end
  end

  assign bus.bcd_out  = w_value;
  assign bus.running  = r_running;
  assign bus.expired  = r_expired;
  assign bus.alarm    = r_alarm;
  assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_tick_countdown.sv
// Directed bench: three timer configurations share one stimulus stream.
module tb_tick_countdown;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_in = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_bcd = '0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  tick_countdown_if ifa ();
  tick_countdown_if ifb ();
  tick_countdown_if ifc ();

  assign ifa.tick_in = tick_in;  assign ifb.tick_in = tick_in;  assign ifc.tick_in = tick_in;
  assign ifa.load = load;        assign ifb.load = load;        assign ifc.load = load;
  assign ifa.load_bcd = load_bcd; assign ifb.load_bcd = load_bcd; assign ifc.load_bcd = load_bcd;
  assign ifa.start = start;      assign ifb.start = start;      assign ifc.start = start;
  assign ifa.pause = pause;      assign ifb.pause = pause;      assign ifc.pause = pause;
  assign ifa.clear = clear;      assign ifb.clear = clear;      assign ifc.clear = clear;

  tick_countdown #(.EDGE_DETECT(1), .ALARM_TICKS(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  tick_countdown #(.EDGE_DETECT(1), .ALARM_TICKS(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  tick_countdown #(.EDGE_DETECT(0), .ALARM_TICKS(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_bcd = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic tick_and_gap();
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    step();
    step();
    check("rst_bcd",      ifa.bcd_out, 16'h0000);
    check("rst_running",  16'(ifa.running), 16'h0);
    check("rst_expired",  16'(ifa.expired), 16'h0);
    check("rst_alarm",    16'(ifa.alarm), 16'h0);
    check("rst_load_err", 16'(ifa.load_err), 16'h0);
    rst = 1'b0;
    step();

    // 1: basic run to expiry, alarm behaviour in DONE
    do_load(16'h0003);
    check("t1_load", ifa.bcd_out, 16'h0003);
    do_start();
    check("t1_running", 16'(ifa.running), 16'h1);
    tick_and_gap();
    check("t1_tick1", ifa.bcd_out, 16'h0002);
    check("t1_noexp", 16'(ifa.expired), 16'h0);
    tick_and_gap();
    check("t1_tick2", ifa.bcd_out, 16'h0001);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    check("t1_tick3",     ifa.bcd_out, 16'h0000);
    check("t1_expired",   16'(ifa.expired), 16'h1);
    check("t1_alarm",     16'(ifa.alarm), 16'h1);
    check("t1_alarm_b",   16'(ifb.alarm), 16'h1);
    check("t1_run_off",   16'(ifa.running), 16'h0);
    step();
    check("t1_exp_pulse", 16'(ifa.expired), 16'h0);
    check("t1_alarm_hold", 16'(ifa.alarm), 16'h1);
    do_start();
    check("t1_done_start", 16'(ifa.running), 16'h0);
    tick_and_gap();
    check("t1_nowrap",    ifa.bcd_out, 16'h0000);
    check("t1_b_alarm1",  16'(ifb.alarm), 16'h1);
    tick_and_gap();
    check("t1_b_alarm2",  16'(ifb.alarm), 16'h0);
    check("t1_a_alarm2",  16'(ifa.alarm), 16'h1);
    check("t1_b_nowrap",  ifb.bcd_out, 16'h0000);
    do_clear();
    check("t1_clr_alarm", 16'(ifa.alarm), 16'h0);
    check("t1_clr_bcd",   ifa.bcd_out, 16'h0000);

    // 2: borrow chains
    do_reset();
    do_load(16'h0100);
    do_start();
    tick_and_gap();
    check("t2_0100", ifa.bcd_out, 16'h0059);
    do_load(16'h1000);
    check("t2_ld_idle", 16'(ifa.running), 16'h0);
    do_start();
    tick_and_gap();
    check("t2_1000", ifa.bcd_out, 16'h0959);

    // 3: rejected loads leave value and state alone
    do_load(16'h0065);
    check("t3_err1",     16'(ifa.load_err), 16'h1);
    check("t3_keep1",    ifa.bcd_out, 16'h0959);
    check("t3_run_keep", 16'(ifa.running), 16'h1);
    step();
    check("t3_err_pulse", 16'(ifa.load_err), 16'h0);
    do_load(16'h0A00);
    check("t3_err2",  16'(ifa.load_err), 16'h1);
    check("t3_keep2", ifa.bcd_out, 16'h0959);
    step();

    // 4: pause beats a coincident tick; ticks ignored while paused
    do_reset();
    do_load(16'h0010);
    do_start();
    pause = 1'b1;
    tick_in = 1'b1;
    step();
    pause = 1'b0;
    tick_in = 1'b0;
    check("t4_pause_tick", ifa.bcd_out, 16'h0010);
    check("t4_paused",     16'(ifa.running), 16'h0);
    step();
    for (int unsigned i = 0; i < 3; i++) tick_and_gap();
    check("t4_pause_hold", ifa.bcd_out, 16'h0010);
    do_start();
    check("t4_resume", 16'(ifa.running), 16'h1);
    start = 1'b1;
    pause = 1'b1;
    step();
    start = 1'b0;
    pause = 1'b0;
    check("t4_both_run", 16'(ifa.running), 16'h1);
    tick_and_gap();
    check("t4_dec", ifa.bcd_out, 16'h0009);

    // 5: tick held high: edge mode decrements once, level mode every cycle
    do_reset();
    do_load(16'h0010);
    do_start();
    tick_in = 1'b1;
    repeat (5) step();
    tick_in = 1'b0;
    step();
    check("t5_edge",  ifa.bcd_out, 16'h0009);
    check("t5_level", ifc.bcd_out, 16'h0005);

    // 6: reset mid-count discards the in-flight tick
    do_reset();
    do_load(16'h0042);
    do_start();
    rst = 1'b1;
    tick_in = 1'b1;
    step();
    rst = 1'b0;
    tick_in = 1'b0;
    check("t6_bcd",     ifa.bcd_out, 16'h0000);
    check("t6_running", 16'(ifa.running), 16'h0);
    do_start();
    check("t6_start0", 16'(ifa.running), 16'h0);
    tick_and_gap();
    check("t6_hold0", ifa.bcd_out, 16'h0000);

    // clear aborts a running count
    do_load(16'h0005);
    do_start();
    do_clear();
    check("clr_bcd",     ifa.bcd_out, 16'h0000);
    check("clr_running", 16'(ifa.running), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
